axi_lite_user_bridge: RTL and testbench

Parametrised AXI4-Lite slave bridging the PS general-purpose port to a simple user register bus. It is the successor to the fixed 32-bit-address, single-IRQ, zero-wait-state lite bridge. It adds:
- a configurable user address width;
- user-side wait states (wr_ack / rd_valid handshakes) with a timeout that returns SLVERR;
- NUM_IRQ user interrupt lines with internal pending/mask registers.

User logic runs on the AXI clock.

---
 rtl/axi_lite_user_pkg.sv | 21 ++
 rtl/axi_lite_user_irq.sv | 64 ++++++
 rtl/axi_lite_user_bridge.sv | 187 ++++++++++++++++++
 tb/tb_axi_lite_user_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_user_pkg.sv
// rtl/axi_lite_user_pkg.sv - shared response codes, register offsets and FSM states for the user bridge
package axi_lite_user_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CLEAR   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

endpackage

// File: rtl/axi_lite_user_irq.sv
// rtl/axi_lite_user_irq.sv - user interrupt edge detect, pending/mask registers and host interrupt
module axi_lite_user_irq
  import axi_lite_user_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               reg_wr,
  input  logic [1:0]         reg_off,
  input  logic [31:0]        reg_wdata,
  input  logic [3:0]         reg_wstrb,
  output logic [31:0]        reg_rdata,
  output logic               host_interrupt
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mask_nxt;
  logic [NUM_IRQ-1:0] clr_bits;
  logic [31:0]        byte_en;
  logic               unused_wr_bits;

  assign byte_en = {{8{reg_wstrb[3]}}, {8{reg_wstrb[2]}}, {8{reg_wstrb[1]}}, {8{reg_wstrb[0]}}};
  assign unused_wr_bits = ^{reg_wdata, byte_en};

  always_comb begin
    mask_nxt = mask;
    clr_bits = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (reg_wr && reg_off == REG_MASK && byte_en[i])
        mask_nxt[i] = reg_wdata[i];
      if (reg_wr && reg_off == REG_CLEAR && byte_en[i] && reg_wdata[i])
        clr_bits[i] = 1'b1;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      REG_PENDING: reg_rdata[NUM_IRQ-1:0] = pending;
      REG_MASK:    reg_rdata[NUM_IRQ-1:0] = mask;
      default:     reg_rdata = '0;
    endcase
  end

  // A fresh edge is OR-ed in after the clear, so set beats clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q          <= '0;
      pending        <= '0;
      mask           <= '0;
      host_interrupt <= 1'b0;
    end else begin
      irq_q          <= irq;
      pending        <= (pending & ~clr_bits) | (irq & ~irq_q);
      mask           <= mask_nxt;
      host_interrupt <= |(pending & mask);
    end
  end

endmodule

// File: rtl/axi_lite_user_bridge.sv
// rtl/axi_lite_user_bridge.sv - AXI4-Lite slave to user register bus with wait states, timeout and IRQ block
module axi_lite_user_bridge
  import axi_lite_user_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int NUM_IRQ     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [31:0]        S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic [3:0]         S_AXI_WSTRB,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [31:0]        S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  output logic               user_clk,
  output logic [ADDR_W-1:0]  user_addr,
  output logic               user_wren,
  output logic [3:0]         user_wstrb,
  output logic [31:0]        user_wr_data,
  input  logic               user_wr_ack,
  output logic               user_rden,
  input  logic [31:0]        user_rd_data,
  input  logic               user_rd_valid,
  input  logic [NUM_IRQ-1:0] user_irq,
  output logic               host_interrupt
);

  state_t            state, state_nxt;
  logic              active;
  logic              prefer_wr;
  logic [ADDR_W:0]   addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [15:0]       cnt;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;
  logic              internal;
  logic              timeout;
  logic              take_wr, take_rd;
  logic              irq_wr;
  logic [31:0]       irq_rdata;
  logic              unused_addr;

  assign user_clk     = S_AXI_ACLK;
  assign internal     = addr_q[ADDR_W];
  assign user_addr    = addr_q[ADDR_W-1:0];
  assign user_wstrb   = wstrb_q;
  assign user_wr_data = wdata_q;
  assign timeout      = (cnt == 16'(TIMEOUT_CYC - 1));
  assign unused_addr  = ^{S_AXI_AWADDR[31:ADDR_W+1], S_AXI_ARADDR[31:ADDR_W+1]};

  assign S_AXI_BVALID = (state == WR_RESP);
  assign S_AXI_RVALID = (state == RD_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

  // active keeps the READYs low while reset is asserted even if a master drives VALID.
  assign take_wr = active && S_AXI_AWVALID && S_AXI_WVALID && (prefer_wr || !S_AXI_ARVALID);
  assign take_rd = active && S_AXI_ARVALID && !take_wr;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    user_wren     = 1'b0;
    user_rden     = 1'b0;
    irq_wr        = 1'b0;
    case (state)
      IDLE: begin
        if (take_wr) begin
          S_AXI_AWREADY = 1'b1;
          S_AXI_WREADY  = 1'b1;
          state_nxt     = WR_ISSUE;
        end else if (take_rd) begin
          S_AXI_ARREADY = 1'b1;
          state_nxt     = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (internal) begin
          irq_wr    = 1'b1;
          state_nxt = WR_RESP;
        end else begin
          user_wren = 1'b1;
          state_nxt = user_wr_ack ? WR_RESP : WR_WAIT;
        end
      end
      WR_WAIT:  if (user_wr_ack || timeout) state_nxt = WR_RESP;
      WR_RESP:  if (S_AXI_BREADY) state_nxt = IDLE;
      RD_ISSUE: begin
        if (internal) begin
          state_nxt = RD_RESP;
        end else begin
          user_rden = 1'b1;
          state_nxt = user_rd_valid ? RD_RESP : RD_WAIT;
        end
      end
      RD_WAIT:  if (user_rd_valid || timeout) state_nxt = RD_RESP;
      RD_RESP:  if (S_AXI_RREADY) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      active    <= 1'b0;
      prefer_wr <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt       <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      active <= 1'b1;
      if (S_AXI_AWREADY) begin
        addr_q    <= S_AXI_AWADDR[ADDR_W:0];
        wdata_q   <= S_AXI_WDATA;
        wstrb_q   <= S_AXI_WSTRB;
        prefer_wr <= 1'b0;
      end
      if (S_AXI_ARREADY) begin
        addr_q    <= S_AXI_ARADDR[ADDR_W:0];
        prefer_wr <= 1'b1;
      end
      case (state)
        WR_ISSUE, RD_ISSUE: cnt <= '0;
        WR_WAIT,  RD_WAIT:  cnt <= cnt + 16'd1;
        default:            cnt <= cnt;
      endcase
      if (state == WR_ISSUE)
        bresp_q <= RESP_OKAY;
      if (state == WR_WAIT)
        bresp_q <= (!user_wr_ack && timeout) ? RESP_SLVERR : RESP_OKAY;
      if (state == RD_ISSUE) begin
        rresp_q <= RESP_OKAY;
        if (internal)           rdata_q <= irq_rdata;
        else if (user_rd_valid) rdata_q <= user_rd_data;
      end
      if (state == RD_WAIT) begin
        if (user_rd_valid) begin
          rdata_q <= user_rd_data;
          rresp_q <= RESP_OKAY;
        end else if (timeout) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
    end
  end

  axi_lite_user_irq #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk            (S_AXI_ACLK),
    .rst_n          (S_AXI_ARESETN),
    .irq            (user_irq),
    .reg_wr         (irq_wr),
    .reg_off        (addr_q[3:2]),
    .reg_wdata      (wdata_q),
    .reg_wstrb      (wstrb_q),
    .reg_rdata      (irq_rdata),
    .host_interrupt (host_interrupt)
  );

endmodule

// File: tb/tb_axi_lite_user_bridge.sv
// tb/tb_axi_lite_user_bridge.sv - directed self-checking bench for axi_lite_user_bridge
module tb_axi_lite_user_bridge;

  localparam int TO = 8;

  logic        clk, rst_n;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, user_wr_data, user_rd_data;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB, user_wstrb, user_irq;
  logic [1:0]  BRESP, RRESP;
  logic        user_clk, user_wren, user_wr_ack, user_rden, user_rd_valid, host_interrupt;
  logic [11:0] user_addr;
  logic        any_out;

  int checks = 0;
  int errors = 0;

  axi_lite_user_bridge #(.ADDR_W(12), .NUM_IRQ(4), .TIMEOUT_CYC(TO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .user_clk(user_clk), .user_addr(user_addr), .user_wren(user_wren), .user_wstrb(user_wstrb),
    .user_wr_data(user_wr_data), .user_wr_ack(user_wr_ack), .user_rden(user_rden),
    .user_rd_data(user_rd_data), .user_rd_valid(user_rd_valid), .user_irq(user_irq),
    .host_interrupt(host_interrupt)
  );

  assign any_out = |{AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
                     user_addr, user_wren, user_wstrb, user_wr_data, user_rden, host_interrupt};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    int          hold;
    bit          late;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    int          pulses;
    logic [11:0] ua;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input vec_t v, output logic [1:0] resp, output logic [31:0] rd,
                      output int lat, output int pulses, output logic [11:0] ua,
                      output logic [31:0] uwd, output logic [3:0] uws, output bit stable);
    bit acc, ackv, vld;
    int c, iss;
    resp = '0; rd = '0; lat = -1; pulses = 0; ua = '0; uwd = '0; uws = '0;
    stable = 1'b1; iss = -1; acc = 1'b0; c = 0;
    if (v.wr) begin
      AWADDR = v.addr; WDATA = v.data; WSTRB = v.strb; AWVALID = 1'b1; WVALID = 1'b1;
    end else begin
      ARADDR = v.addr; ARVALID = 1'b1;
    end
    #1;
    for (int k = 0; k < 20; k++) begin
      acc = v.wr ? (AWREADY && WREADY) : ARREADY;
      if (acc) break;
      tick(); #1;
    end
    check("accept", 32'(acc), 32'd1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      c++;
      if (v.wr ? user_wren : user_rden) begin
        pulses++;
        if (iss < 0) begin
          iss = c; ua = user_addr; uwd = user_wr_data; uws = user_wstrb;
        end
      end
      ackv = (iss > 0) && (v.dly >= 0) && (c - iss == v.dly);
      if (v.wr) user_wr_ack = ackv;
      else begin
        user_rd_valid = ackv;
        user_rd_data  = ackv ? v.data : 32'hDEAD_BEEF;
      end
      vld = v.wr ? BVALID : RVALID;
      if (vld) begin
        lat = c;
        break;
      end
      tick();
    end
    user_wr_ack = 1'b0;
    user_rd_valid = 1'b0;
    if (lat >= 0) begin
      resp = v.wr ? BRESP : RRESP;
      rd = RDATA;
      for (int h = 0; h < v.hold; h++) begin
        tick(); #1;
        if (!(v.wr ? BVALID : RVALID) || RDATA !== rd || (v.wr ? BRESP : RRESP) !== resp)
          stable = 1'b0;
      end
      if (v.wr) BREADY = 1'b1; else RREADY = 1'b1;
      tick();
      BREADY = 1'b0; RREADY = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    user_wr_ack = 0; user_rd_valid = 0; user_irq = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [1:0]  resp;
  logic [31:0] rd, uwd;
  logic [11:0] ua;
  logic [3:0]  uws;
  int          lat, pulses, n;
  bit          stable, seen;
  int          seq[4];
  vec_t        v;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 0,  0, 1'b0, 2'b00, 32'h0, 2,      1, 12'h010};
    vecs[1]  = '{1'b0, 32'h0000_0024, 32'h1234_5678, 4'h0, 5,  3, 1'b0, 2'b00, 32'h1234_5678, 7, 1, 12'h024};
    vecs[2]  = '{1'b0, 32'h0000_0100, 32'hCAFE_0008, 4'h0, TO, 0, 1'b0, 2'b00, 32'hCAFE_0008, TO + 2, 1, 12'h100};
    vecs[3]  = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, -1, 0, 1'b1, 2'b10, 32'h0, TO + 2, 1, 12'h104};
    vecs[4]  = '{1'b0, 32'h0000_0108, 32'h0000_0444, 4'h0, 1,  0, 1'b0, 2'b00, 32'h0000_0444, 3, 1, 12'h108};
    vecs[5]  = '{1'b1, 32'h0000_0200, 32'h0000_BEEF, 4'h3, TO + 1, 0, 1'b0, 2'b10, 32'h0, TO + 2, 1, 12'h200};
    vecs[6]  = '{1'b1, 32'h0000_4010, 32'h0000_0011, 4'h3, 2,  0, 1'b0, 2'b00, 32'h0, 4,      1, 12'h010};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, -1, 0, 1'b0, 2'b00, 32'h0, 2,      0, 12'h000};
    vecs[8]  = '{1'b1, 32'h0000_1004, 32'h0000_0005, 4'hF, -1, 0, 1'b0, 2'b00, 32'h0, 2,      0, 12'h000};
    vecs[9]  = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, -1, 0, 1'b0, 2'b00, 32'h5, 2,      0, 12'h000};
    vecs[10] = '{1'b1, 32'h0000_1004, 32'h0000_000F, 4'hE, -1, 0, 1'b0, 2'b00, 32'h0, 2,      0, 12'h000};
    vecs[11] = '{1'b0, 32'hFFFF_1004, 32'h0,         4'h0, -1, 0, 1'b0, 2'b00, 32'h5, 2,      0, 12'h000};
    vecs[12] = '{1'b1, 32'h0000_100C, 32'hFFFF_FFFF, 4'hF, -1, 0, 1'b0, 2'b00, 32'h0, 2,      0, 12'h000};
    vecs[13] = '{1'b0, 32'h0000_100C, 32'h0,         4'h0, -1, 0, 1'b0, 2'b00, 32'h0, 2,      0, 12'h000};

    AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0; user_rd_data = '0;
    rst_n = 1'b0;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    user_wr_ack = 0; user_rd_valid = 0; user_irq = '0;
    #3;
    check("reset_outs_low", 32'(any_out), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    #1;
    check("reset_outs_after", 32'(any_out), 32'd0);

    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i], resp, rd, lat, pulses, ua, uwd, uws, stable);
      check($sformatf("v%0d_resp", i), 32'(resp), 32'(vecs[i].resp));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].pulses));
      if (vecs[i].pulses > 0) check($sformatf("v%0d_uaddr", i), 32'(ua), 32'(vecs[i].ua));
      if (vecs[i].wr && vecs[i].pulses > 0) begin
        check($sformatf("v%0d_uwdata", i), uwd, vecs[i].data);
        check($sformatf("v%0d_uwstrb", i), 32'(uws), 32'(vecs[i].strb));
      end
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      if (vecs[i].hold > 0) check($sformatf("v%0d_stable", i), 32'(stable), 32'd1);
      if (vecs[i].late) begin
        user_rd_valid = 1'b1;
        user_rd_data  = 32'hBAD0_BAD0;
        repeat (3) tick();
        user_rd_valid = 1'b0;
      end
    end

    // rising edge on irq[2] with MASK=5: pending one edge later, host_interrupt one more
    user_irq = 4'b0100;
    #1;
    check("irq_host_pre", 32'(host_interrupt), 32'd0);
    tick();
    check("irq_host_lag", 32'(host_interrupt), 32'd0);
    user_irq = 4'b0000;
    tick();
    check("irq_host_set", 32'(host_interrupt), 32'd1);
    v = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, -1, 0, 1'b0, 2'b00, 32'h4, 2, 0, 12'h000};
    xfer(v, resp, rd, lat, pulses, ua, uwd, uws, stable);
    check("irq_pending_read", rd, 32'h4);

    // CLEAR in the same cycle as a new rising edge: set wins
    AWADDR = 32'h0000_1008; WDATA = 32'h4; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    check("clr_race_accept", 32'(AWREADY && WREADY), 32'd1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; user_irq = 4'b0100;
    tick();
    check("clr_race_bvalid", 32'(BVALID), 32'd1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0; user_irq = 4'b0000;
    xfer(v, resp, rd, lat, pulses, ua, uwd, uws, stable);
    check("clr_race_pending", rd, 32'h4);
    check("clr_race_host", 32'(host_interrupt), 32'd1);

    // plain clear: host_interrupt falls one cycle after pending
    AWADDR = 32'h0000_1008; WDATA = 32'h4; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    check("clr_accept", 32'(AWREADY && WREADY), 32'd1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    check("clr_host_still", 32'(host_interrupt), 32'd1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("clr_host_drop", 32'(host_interrupt), 32'd0);
    xfer(v, resp, rd, lat, pulses, ua, uwd, uws, stable);
    check("clr_pending", rd, 32'h0);

    // reset while a user write is waiting
    user_irq = 4'b0001;
    tick();
    user_irq = 4'b0000;
    tick();
    check("rst_host_before", 32'(host_interrupt), 32'd1);
    AWADDR = 32'h0000_0300; WDATA = 32'h7777_0000; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    check("rst_wr_accept", 32'(AWREADY && WREADY), 32'd1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("rst_outs_zero", 32'(any_out), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (BVALID) seen = 1'b1;
    end
    check("rst_no_bvalid", 32'(seen), 32'd0);
    v = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, -1, 0, 1'b0, 2'b00, 32'h0, 2, 0, 12'h000};
    xfer(v, resp, rd, lat, pulses, ua, uwd, uws, stable);
    check("rst_mask_zero", rd, 32'h0);

    // arbitration with both requests always pending
    apply_reset();
    AWADDR = 32'h0000_0020; WDATA = 32'h1; WSTRB = 4'hF; ARADDR = 32'h0000_0030;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    BREADY = 1'b1; RREADY = 1'b1; user_wr_ack = 1'b1; user_rd_valid = 1'b1; user_rd_data = '0;
    for (int j = 0; j < 4; j++) seq[j] = 2;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      #1;
      if (AWREADY && WREADY) begin seq[n] = 1; n++; end
      else if (ARREADY)      begin seq[n] = 0; n++; end
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    repeat (4) tick();
    BREADY = 1'b0; RREADY = 1'b0; user_wr_ack = 1'b0; user_rd_valid = 1'b0;
    check("arb_count", 32'(n), 32'd4);
    check("arb_0_write", 32'(seq[0]), 32'd1);
    check("arb_1_read", 32'(seq[1]), 32'd0);
    check("arb_2_write", 32'(seq[2]), 32'd1);
    check("arb_3_read", 32'(seq[3]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
